// File: rtl/sump_cmd_seq_if.sv
// Byte-stream and decoder-side signals of the SUMP command sequencer.
// slave: the sequencer itself; master: the UART side / bench that drives bytes.
interface sump_cmd_seq_if;
   logic        rx_stb_i;
   logic [7:0]  rx_dat_i;
   logic        stb_o;
   logic [7:0]  opc_o;
   logic [31:0] cmd_o;
   logic        busy_o;
   logic        tout_o;

   modport slave (
      input  rx_stb_i, rx_dat_i,
      output stb_o, opc_o, cmd_o, busy_o, tout_o
   );

   modport master (
      output rx_stb_i, rx_dat_i,
      input  stb_o, opc_o, cmd_o, busy_o, tout_o
   );
endinterface

// File: rtl/sump_cmd_seq.sv
// Assembles SUMP short (1 byte) and long (opcode + 4 argument bytes) commands
// into one decoder strobe each. Define LOGIP_CMD_TIMEOUT_EN to abort stalled long commands.
module sump_cmd_seq #(
   parameter int TIMEOUT = 100000
) (
   input  logic          clk_i,
   input  logic          rst_in,
   sump_cmd_seq_if.slave bus
);

   typedef enum logic {IDLE, ARG} state_t;

   state_t      state_reg, state_next;
   logic [1:0]  cnt_reg, cnt_next;
   logic [7:0]  opc_lat_reg, opc_lat_next;
   logic [31:0] arg_reg, arg_next;
   logic        arg_we;
   logic        stb_reg, stb_next;
   logic [7:0]  opc_reg, opc_next;
   logic [31:0] cmd_reg, cmd_next;
   logic        busy_reg, busy_next;

`ifdef LOGIP_CMD_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT + 1);
   logic [TO_W-1:0] tcnt_reg, tcnt_next;
   logic            tout_reg, tout_next;
`endif

   // One write port per argument slot, selected by the byte counter.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_slot
         assign arg_next[gi*8 +: 8] = (arg_we && cnt_reg == 2'(gi)) ? bus.rx_dat_i
                                                                     : arg_reg[gi*8 +: 8];
      end
   endgenerate

   always_comb begin
      state_next   = state_reg;
      cnt_next     = cnt_reg;
      opc_lat_next = opc_lat_reg;
      opc_next     = opc_reg;
      cmd_next     = cmd_reg;
      busy_next    = busy_reg;
      stb_next     = 1'b0;
      arg_we       = 1'b0;
`ifdef LOGIP_CMD_TIMEOUT_EN
      tcnt_next    = tcnt_reg;
      tout_next    = 1'b0;
`endif
      case (state_reg)
         IDLE: begin
`ifdef LOGIP_CMD_TIMEOUT_EN
            tcnt_next = '0;
`endif
            if (bus.rx_stb_i) begin
               if (!bus.rx_dat_i[7]) begin
                  opc_next = bus.rx_dat_i;
                  cmd_next = '0;
                  stb_next = 1'b1;
               end else begin
                  opc_lat_next = bus.rx_dat_i;
                  cnt_next     = 2'd0;
                  busy_next    = 1'b1;
                  state_next   = ARG;
               end
            end
         end
         ARG: begin
`ifdef LOGIP_CMD_TIMEOUT_EN
            // Timeout cycle: tout_o is already high, any byte here is dropped.
            if (tcnt_reg == TO_W'(TIMEOUT)) begin
               state_next = IDLE;
               tcnt_next  = '0;
               cnt_next   = 2'd0;
            end else
`endif
            if (bus.rx_stb_i) begin
               arg_we = 1'b1;
`ifdef LOGIP_CMD_TIMEOUT_EN
               tcnt_next = '0;
`endif
               if (cnt_reg == 2'd3) begin
                  opc_next   = opc_lat_reg;
                  cmd_next   = {bus.rx_dat_i, arg_reg[23:0]};
                  stb_next   = 1'b1;
                  busy_next  = 1'b0;
                  cnt_next   = 2'd0;
                  state_next = IDLE;
               end else begin
                  cnt_next = cnt_reg + 2'd1;
               end
            end else begin
`ifdef LOGIP_CMD_TIMEOUT_EN
               tcnt_next = tcnt_reg + 1'b1;
               if (tcnt_reg == TO_W'(TIMEOUT - 1)) begin
                  tout_next = 1'b1;
                  busy_next = 1'b0;
               end
`endif
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_in) begin
      if (!rst_in) begin
         state_reg   <= IDLE;
         cnt_reg     <= 2'd0;
         opc_lat_reg <= 8'd0;
         arg_reg     <= 32'd0;
         stb_reg     <= 1'b0;
         opc_reg     <= 8'd0;
         cmd_reg     <= 32'd0;
         busy_reg    <= 1'b0;
`ifdef LOGIP_CMD_TIMEOUT_EN
         tcnt_reg    <= '0;
         tout_reg    <= 1'b0;
`endif
      end else begin
         state_reg   <= state_next;
         cnt_reg     <= cnt_next;
         opc_lat_reg <= opc_lat_next;
         arg_reg     <= arg_next;
         stb_reg     <= stb_next;
         opc_reg     <= opc_next;
         cmd_reg     <= cmd_next;
         busy_reg    <= busy_next;
`ifdef LOGIP_CMD_TIMEOUT_EN
         tcnt_reg    <= tcnt_next;
         tout_reg    <= tout_next;
`endif
      end
   end

   assign bus.stb_o  = stb_reg;
   assign bus.opc_o  = opc_reg;
   assign bus.cmd_o  = cmd_reg;
   assign bus.busy_o = busy_reg;
`ifdef LOGIP_CMD_TIMEOUT_EN
   assign bus.tout_o = tout_reg;
`else
   assign bus.tout_o = 1'b0;
`endif

endmodule

// File: tb/tb_sump_cmd_seq.sv
// Bench for sump_cmd_seq: a byte-queue command model checked every cycle,
// plus literal checks on the captured strobes of each directed scenario.
module tb_sump_cmd_seq;

`ifdef LOGIP_CMD_TIMEOUT_EN
   localparam int TMO = 16;
`else
   localparam int TMO = 100000;
`endif

   logic clk_i = 1'b0;
   logic rst_in = 1'b0;
   always #5 clk_i = ~clk_i;

   sump_cmd_seq_if bus ();

   sump_cmd_seq #(.TIMEOUT(TMO)) dut (
      .clk_i  (clk_i),
      .rst_in (rst_in),
      .bus    (bus.slave)
   );

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: bytes of the command in progress, compared against expected outputs.
   logic [7:0]  q[$];
   logic        exp_stb = 1'b0, exp_busy = 1'b0, exp_tout = 1'b0;
   logic [7:0]  exp_opc = 8'd0;
   logic [31:0] exp_cmd = 32'd0;
   int          idle = 0;
   bit          to_pend = 1'b0;

   always @(posedge clk_i or negedge rst_in) begin
      if (!rst_in) begin
         q.delete();
         exp_stb = 0; exp_busy = 0; exp_tout = 0; exp_opc = 0; exp_cmd = 0;
         idle = 0; to_pend = 0;
      end else begin
         exp_stb  = 0;
         exp_tout = 0;
         if (to_pend) begin
            to_pend = 0;
            q.delete();
            idle = 0;
         end else if (bus.rx_stb_i) begin
            idle = 0;
            q.push_back(bus.rx_dat_i);
            if (q[0] < 8'h80) begin
               exp_stb = 1; exp_opc = q[0]; exp_cmd = 0;
               q.delete();
            end else if (q.size() == 5) begin
               exp_stb = 1; exp_opc = q[0];
               exp_cmd = 32'(q[1]) + 32'(q[2]) * 256 + 32'(q[3]) * 65536 + 32'(q[4]) * 16777216;
               q.delete();
            end
         end else if (q.size() > 0) begin
`ifdef LOGIP_CMD_TIMEOUT_EN
            idle++;
            if (idle == TMO) begin
               exp_tout = 1;
               to_pend  = 1;
            end
`endif
         end
         exp_busy = (q.size() > 0) && !to_pend;
      end
   end

   // Per-cycle compare, and capture of every strobe for the literal checks.
   logic [39:0] sq[$];
   int tout_seen = 0;

   always @(posedge clk_i) begin
      #1;
      check("stb",  32'(bus.stb_o),  32'(exp_stb));
      check("busy", 32'(bus.busy_o), 32'(exp_busy));
      check("tout", 32'(bus.tout_o), 32'(exp_tout));
      check("opc",  32'(bus.opc_o),  32'(exp_opc));
      check("cmd",  bus.cmd_o,       exp_cmd);
      if (bus.stb_o) sq.push_back({bus.opc_o, bus.cmd_o});
      if (bus.tout_o) tout_seen++;
   end

   // Caller is at a negedge; returns at a negedge after gap idle cycles.
   task automatic send(input logic [7:0] b, input int gap);
      bus.rx_stb_i = 1'b1;
      bus.rx_dat_i = b;
      @(negedge clk_i);
      bus.rx_stb_i = 1'b0;
      repeat (gap) @(negedge clk_i);
   endtask

   task automatic pop_strobe(input string name, input logic [7:0] opc, input logic [31:0] cmd);
      logic [39:0] s;
      checks++;
      if (sq.size() == 0) begin
         errors++;
         $display("FAIL %s: got no strobe expected opc %h cmd %h", name, opc, cmd);
      end else begin
         s = sq.pop_front();
         check({name, "_opc"}, 32'(s[39:32]), 32'(opc));
         check({name, "_cmd"}, s[31:0], cmd);
      end
   endtask

   initial begin
      logic [7:0] lbytes[5];
      bus.rx_stb_i = 1'b0;
      bus.rx_dat_i = 8'h00;
      #2;
      check("rst_stb",  32'(bus.stb_o),  0);
      check("rst_opc",  32'(bus.opc_o),  0);
      check("rst_cmd",  bus.cmd_o,       0);
      check("rst_busy", 32'(bus.busy_o), 0);
      repeat (3) @(negedge clk_i);
      rst_in = 1'b1;
      @(negedge clk_i);

      // Short command
      send(8'h01, 3);
      check("short_cnt", 32'(sq.size()), 1);
      pop_strobe("short", 8'h01, 32'h0);

      // Long command with 0-3 cycle gaps
      lbytes = '{8'hC0, 8'h11, 8'h22, 8'h33, 8'h44};
      for (int i = 0; i < 5; i++) begin
         send(lbytes[i], (i == 4) ? 3 : i % 4);
         if (i == 0) check("long_busy", 32'(bus.busy_o), 1);
      end
      pop_strobe("long", 8'hC0, 32'h44332211);

      // Back-to-back, next opcode on the strobe cycle
      send(8'h80, 0); send(8'h05, 0); send(8'h00, 0); send(8'h00, 0); send(8'h00, 0);
      send(8'h02, 3);
      check("b2b_cnt", 32'(sq.size()), 2);
      pop_strobe("b2b_long", 8'h80, 32'h5);
      pop_strobe("b2b_short", 8'h02, 32'h0);

      // Reset mid-command
      send(8'hC1, 0); send(8'hAA, 0); send(8'hBB, 0);
      rst_in = 1'b0;
      #1;
      check("mid_rst_busy", 32'(bus.busy_o), 0);
      check("mid_rst_opc",  32'(bus.opc_o),  0);
      check("mid_rst_cmd",  bus.cmd_o,       0);
      repeat (2) @(negedge clk_i);
      rst_in = 1'b1;
      @(negedge clk_i);
      check("mid_rst_nostb", 32'(sq.size()), 0);
      send(8'h02, 3);
      pop_strobe("after_rst", 8'h02, 32'h0);

`ifdef LOGIP_CMD_TIMEOUT_EN
      send(8'hC2, 0); send(8'h01, TMO + 2);
      check("to_seen", 32'(tout_seen), 1);
      check("to_nostb", 32'(sq.size()), 0);
      send(8'h11, 3);
      pop_strobe("after_to", 8'h11, 32'h0);
`else
      send(8'hC2, 0); send(8'h01, 10000);
      check("wait_busy", 32'(bus.busy_o), 1);
      send(8'h02, 0); send(8'h03, 0); send(8'h04, 3);
      check("wait_cnt", 32'(sq.size()), 1);
      pop_strobe("wait", 8'hC2, 32'h04030201);
      check("no_tout", 32'(tout_seen), 0);
`endif

      repeat (2) @(negedge clk_i);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sump_cmd_seq.md
Name: sump_cmd_seq

Overview:
- Sequences the instruction decoder from the UART receive byte stream.
- Collects SUMP short commands (1 byte) and long commands (opcode plus 4 argument bytes).
- Issues one decoder strobe per complete command, with the opcode and the 32-bit argument word held stable.
- Sits between the UART receiver and indec; the optional inter-byte timeout recovers from a truncated long command.

Parameters:
- TIMEOUT, 100000: max idle cycles allowed between bytes of one long command before it is aborted (used only with the optional feature).
- TO_W, $clog2(TIMEOUT+1): width of the timeout counter; derived, not overridden.

Ports:
- clk_i  in  1  system clock.
- rst_in  in  1  asynchronous active-low reset.
- rx_stb_i  in  1  one-cycle pulse: rx_dat_i holds a new received byte.
- rx_dat_i  in  8  received byte.
- stb_o  out  1  one-cycle command strobe to indec stb_i.
- opc_o  out  8  command opcode to indec opc_i.
- cmd_o  out  32  long-command argument, little-endian; first argument byte in [7:0].
- busy_o  out  1  high while a long command is partially received.
- tout_o  out  1  one-cycle pulse: partial long command discarded by timeout.

Behaviour:
- Reset (async, rst_in=0):
  - All outputs 0: stb_o, opc_o, cmd_o, busy_o, tout_o.
  - FSM to IDLE, byte counter 0, timeout counter 0.
  - Reset mid-command discards all partial bytes; no strobe is issued.
- FSM states: IDLE, ARG.
- IDLE, rx_stb_i=1, rx_dat_i[7]=0 (short command):
  - Next cycle: opc_o=rx_dat_i, cmd_o=0, stb_o=1.
  - Stay in IDLE.
- IDLE, rx_stb_i=1, rx_dat_i[7]=1 (long command):
  - Latch the opcode internally; opc_o and cmd_o stay unchanged.
  - Go to ARG with byte counter 0; busy_o=1 from the next cycle.
- ARG, rx_stb_i=1:
  - Store the byte in argument slot [counter*8 +: 8], then increment the counter.
  - On the 4th byte (counter==3): next cycle opc_o=latched opcode, cmd_o=assembled word, stb_o=1, busy_o=0, FSM to IDLE, counter 0.
- Latency: stb_o rises exactly 1 cycle after the accepted completing byte.
- Strobe timing:
  - stb_o is high for exactly one cycle.
  - opc_o and cmd_o hold their values until the next strobe.
- No back-pressure: a byte arriving on the same cycle as stb_o=1 is accepted normally, so back-to-back bytes are never lost.
- Byte handling:
  - rx_stb_i=0 cycles are ignored; the FSM holds its state.
  - The top bit of argument bytes is not interpreted.
- tout_o is 0 at all times unless the optional feature is compiled in.
- A short-command opcode byte 0x00 (SUMP reset) is strobed like any other short command; its interpretation belongs to indec.

Optional Feature:
- Macro: LOGIP_CMD_TIMEOUT_EN.
- With the macro defined:
  - In ARG, the timeout counter increments on every cycle with rx_stb_i=0 and clears on every accepted byte.
  - When the counter reaches TIMEOUT: FSM to IDLE, partial argument discarded, no stb_o, busy_o=0, tout_o=1 for one cycle, counter cleared.
  - A byte arriving on the timeout cycle is ignored, and is not treated as a new opcode.
  - In IDLE the counter is held at 0.
- Without the macro:
  - No counter logic; tout_o is tied to 0.
  - ARG waits indefinitely for the remaining argument bytes.

Test Plan:
- Short command: reset, then byte 0x01 -> one cycle later stb_o=1 for 1 cycle, opc_o=0x01, cmd_o=0x00000000, busy_o=0 throughout.
- Long command: bytes 0xC0,0x11,0x22,0x33,0x44 with gaps of 0-3 cycles -> busy_o=1 from the cycle after 0xC0 until strobe; one cycle after 0x44: stb_o=1, opc_o=0xC0, cmd_o=0x44332211.
- Back-to-back: 0x80,0x05,0x00,0x00,0x00 immediately followed by 0x02 on the strobe cycle -> strobe {0x80, 0x00000005}, then strobe {0x02, 0} the next cycle; no byte lost.
- Reset mid-command: 0xC1,0xAA,0xBB, then rst_in=0 for 2 cycles -> no strobe, busy_o=0 and outputs 0 immediately on reset; a following 0x02 yields a normal short strobe.
- Timeout (macro defined, TIMEOUT=16): 0xC2,0x01 then 16 idle cycles -> tout_o=1 for 1 cycle, no stb_o; a following 0x11 is taken as a short opcode, giving stb_o with opc_o=0x11.
- Timeout disabled (macro undefined): 0xC2,0x01, 10000 idle cycles, then 0x02,0x03,0x04 -> single strobe opc_o=0xC2, cmd_o=0x04030201; tout_o never asserted.
